// File: rtl/synchronized_request_arbiter.sv
// Round-robin arbiter for asynchronous 4-phase requesters sharing one resource.
// Each request is synchronized; acknowledges and grants come straight from flops.
module synchronized_request_arbiter #(
    parameter int unsigned REQUESTERS = 4,
    parameter int unsigned STAGES     = 2,
    localparam int unsigned IW        = (REQUESTERS > 2) ? $clog2(REQUESTERS) : 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [REQUESTERS-1:0] request,
    output logic [REQUESTERS-1:0] acknowledge,
    output logic                  grant_valid,
    output logic [IW-1:0]         grant_index,
    output logic [REQUESTERS-1:0] grant_onehot,
    input  logic                  done
);

    typedef enum logic {StIdle, StBusy} state_e;

    logic [REQUESTERS-1:0] sync_q [STAGES];
    logic [REQUESTERS-1:0] synced;
    logic [REQUESTERS-1:0] eligible;

    state_e                state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [REQUESTERS-1:0] ack_q, ack_d;
    logic                  gv_q, gv_d;
    logic [IW-1:0]         gi_q, gi_d;
    logic [REQUESTERS-1:0] go_q, go_d;

    logic                  found;
    logic [IW-1:0]         pick;
    logic [IW-1:0]         cand;

    // Plain flop chain per request bit; nothing else samples the raw input.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= request;
            for (int s = 1; s < int'(STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign synced   = sync_q[STAGES-1];
    assign eligible = synced & ~ack_q & ~go_q;

    // First eligible index after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 1; off <= int'(REQUESTERS); off++) begin
            cand = IW'((int'(ptr_q) + off) % int'(REQUESTERS));
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ack_d   = ack_q;
        gv_d    = gv_q;
        gi_d    = gi_q;
        go_d    = go_q;

        // Release runs independently of the FSM; it never touches the current owner.
        for (int i = 0; i < int'(REQUESTERS); i++) begin
            if (ack_q[i] && !synced[i]) begin
                ack_d[i] = 1'b0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gv_d    = 1'b1;
                    gi_d    = pick;
                    go_d    = REQUESTERS'(1) << pick;
                    ptr_d   = pick;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (done) begin
                    ack_d[gi_q] = 1'b1;
                    gv_d        = 1'b0;
                    gi_d        = '0;
                    go_d        = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            ptr_q   <= IW'(REQUESTERS - 1);
            ack_q   <= '0;
            gv_q    <= 1'b0;
            gi_q    <= '0;
            go_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            gv_q    <= gv_d;
            gi_q    <= gi_d;
            go_q    <= go_d;
        end
    end

    assign acknowledge  = ack_q;
    assign grant_valid  = gv_q;
    assign grant_index  = gi_q;
    assign grant_onehot = go_q;

endmodule

// File: tb/tb_synchronized_request_arbiter.sv
// Self-checking bench for synchronized_request_arbiter (4 requesters, 2 sync stages).
module tb_synchronized_request_arbiter;

    localparam int N   = 4;
    localparam int STG = 2;
    localparam int IW  = 2;

    logic          clock = 1'b0;
    logic          resetn;
    logic [N-1:0]  request;
    logic [N-1:0]  acknowledge;
    logic          grant_valid;
    logic [IW-1:0] grant_index;
    logic [N-1:0]  grant_onehot;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int pend_q[$];

    always #5 clock = ~clock;

    synchronized_request_arbiter #(
        .REQUESTERS(N),
        .STAGES    (STG)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .request     (request),
        .acknowledge (acknowledge),
        .grant_valid (grant_valid),
        .grant_index (grant_index),
        .grant_onehot(grant_onehot),
        .done        (done)
    );

    task automatic do_reset();
        @(negedge clock);
        resetn  = 1'b0;
        request = '0;
        done    = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        request = '0;
        done    = 1'b0;
        #7;
        n_checks++;
        if (acknowledge !== '0) begin
            n_fail++; $display("FAIL reset_ack: got %b required 0000", acknowledge);
        end
        n_checks++;
        if (grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b required 0", grant_valid);
        end
        n_checks++;
        if (grant_index !== '0) begin
            n_fail++; $display("FAIL reset_index: got %0d required 0", grant_index);
        end
        n_checks++;
        if (grant_onehot !== '0) begin
            n_fail++; $display("FAIL reset_onehot: got %b required 0000", grant_onehot);
        end
    endtask

    task automatic test_single();
        int  exp;
        logic want;
        do_reset();
        exp_q.push_back(2);
        request[2] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock); #1;
            want = (e == 3);
            n_checks++;
            if (grant_valid !== want) begin
                n_fail++;
                $display("FAIL single_latency edge %0d: grant_valid=%b required %b", e, grant_valid, want);
            end
        end
        exp = exp_q.pop_front();
        n_checks++;
        if (grant_index !== IW'(exp) || grant_onehot !== N'(1 << exp)) begin
            n_fail++;
            $display("FAIL single_grant: index=%0d onehot=%b required %0d / %b",
                     grant_index, grant_onehot, exp, N'(1 << exp));
        end
        repeat (4) @(posedge clock);
        #1;
        n_checks++;
        if (grant_valid !== 1'b1 || grant_index !== 2'd2) begin
            n_fail++;
            $display("FAIL single_hold: valid=%b index=%0d required 1 / 2", grant_valid, grant_index);
        end
        done = 1'b1;
        @(posedge clock); #1;
        done = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || grant_onehot !== '0 || grant_index !== '0 || acknowledge !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_done: valid=%b onehot=%b index=%0d ack=%b required 0/0000/0/0100",
                     grant_valid, grant_onehot, grant_index, acknowledge);
        end
        request[2] = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock); #1;
            want = (e < 3);
            n_checks++;
            if (acknowledge[2] !== want) begin
                n_fail++;
                $display("FAIL single_release edge %0d: ack[2]=%b required %b", e, acknowledge[2], want);
            end
        end
    endtask

    task automatic test_grant_gap();
        int cyc;
        do_reset();
        request = 4'b1111;
        cyc = 0;
        do begin @(posedge clock); #1; cyc++; end while (!grant_valid && cyc < 20);
        n_checks++;
        if (grant_valid !== 1'b1 || grant_index !== 2'd0) begin
            n_fail++;
            $display("FAIL gap_first: valid=%b index=%0d required 1 / 0", grant_valid, grant_index);
        end
        done = 1'b1;
        @(posedge clock); #1;
        done = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL gap_low: valid=%b required 0", grant_valid);
        end
        @(posedge clock); #1;
        n_checks++;
        if (grant_valid !== 1'b1 || grant_index !== 2'd1 || grant_onehot !== 4'b0010) begin
            n_fail++;
            $display("FAIL gap_next: valid=%b index=%0d onehot=%b required 1/1/0010",
                     grant_valid, grant_index, grant_onehot);
        end
    endtask

    task automatic test_round_robin();
        int   grants;
        int   since;
        int   exp;
        logic prev_v;
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 12; k++) exp_q.push_back(k % N);
        request = 4'b1111;
        grants  = 0;
        since   = 0;
        prev_v  = 1'b0;
        for (int cyc = 0; cyc < 600 && grants < 12; cyc++) begin
            @(posedge clock); #1;
            done = 1'b0;
            if (grant_valid && !prev_v) begin
                grants++;
                since = 0;
                exp = exp_q.pop_front();
                n_checks++;
                if (grant_index !== IW'(exp)) begin
                    n_fail++;
                    $display("FAIL rr_order grant %0d: index=%0d required %0d", grants, grant_index, exp);
                end
            end else if (grant_valid) begin
                since++;
            end
            if (grant_valid && since == 2) done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (request[i] && acknowledge[i]) request[i] = 1'b0;
                else if (!request[i] && !acknowledge[i]) request[i] = 1'b1;
            end
            prev_v = grant_valid;
        end
        done = 1'b0;
        n_checks++;
        if (grants != 12) begin
            n_fail++; $display("FAIL rr_count: grants=%0d required 12", grants);
        end
        exp_q.delete();
    endtask

    task automatic test_spurious_done();
        int cyc;
        do_reset();
        done = 1'b1;
        @(posedge clock); #1;
        done = 1'b0;
        n_checks++;
        if (grant_valid !== 1'b0 || grant_onehot !== '0 || grant_index !== '0 || acknowledge !== '0) begin
            n_fail++;
            $display("FAIL spurious_idle: valid=%b onehot=%b index=%0d ack=%b required all zero",
                     grant_valid, grant_onehot, grant_index, acknowledge);
        end
        request[1] = 1'b1;
        cyc = 0;
        do begin @(posedge clock); #1; cyc++; end while (!grant_valid && cyc < 20);
        n_checks++;
        if (grant_valid !== 1'b1 || grant_index !== 2'd1) begin
            n_fail++;
            $display("FAIL spurious_grant: valid=%b index=%0d required 1 / 1", grant_valid, grant_index);
        end
        done = 1'b1;
        @(posedge clock); #1;
        done = 1'b0;
        @(posedge clock); #1;
        done = 1'b1;
        @(posedge clock); #1;
        done = 1'b0;
        for (int e = 0; e < 2; e++) begin
            n_checks++;
            if (grant_valid !== 1'b0 || grant_onehot !== '0 || grant_index !== '0 || acknowledge !== 4'b0010) begin
                n_fail++;
                $display("FAIL spurious_acked cycle %0d: valid=%b onehot=%b index=%0d ack=%b required 0/0000/0/0010",
                         e, grant_valid, grant_onehot, grant_index, acknowledge);
            end
            @(posedge clock); #1;
        end
        request[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   cyc;
        int   exp;
        logic want;
        do_reset();
        request[1] = 1'b1;
        cyc = 0;
        do begin @(posedge clock); #1; cyc++; end while (!grant_valid && cyc < 20);
        done = 1'b1;
        @(posedge clock); #1;
        done = 1'b0;
        request[3] = 1'b1;
        cyc = 0;
        do begin @(posedge clock); #1; cyc++; end while (!grant_valid && cyc < 20);
        n_checks++;
        if (grant_index !== 2'd3 || acknowledge !== 4'b0010) begin
            n_fail++;
            $display("FAIL mid_setup: index=%0d ack=%b required 3 / 0010", grant_index, acknowledge);
        end
        for (int pass = 0; pass < 2; pass++) begin
            #2;
            resetn     = 1'b0;
            request[1] = 1'b0;
            if (pass == 1) request[0] = 1'b1;
            exp_q.push_back(pass == 1 ? 0 : 3);
            #1;
            n_checks++;
            if (grant_valid !== 1'b0 || grant_onehot !== '0 || grant_index !== '0 || acknowledge !== '0) begin
                n_fail++;
                $display("FAIL mid_async pass %0d: valid=%b onehot=%b index=%0d ack=%b required all zero",
                         pass, grant_valid, grant_onehot, grant_index, acknowledge);
            end
            @(negedge clock);
            resetn = 1'b1;
            for (int e = 1; e <= 3; e++) begin
                @(posedge clock); #1;
                want = (e == 3);
                n_checks++;
                if (grant_valid !== want) begin
                    n_fail++;
                    $display("FAIL mid_latency pass %0d edge %0d: valid=%b required %b", pass, e, grant_valid, want);
                end
            end
            exp = exp_q.pop_front();
            n_checks++;
            if (grant_index !== IW'(exp) || grant_onehot !== N'(1 << exp)) begin
                n_fail++;
                $display("FAIL mid_regrant pass %0d: index=%0d onehot=%b required %0d",
                         pass, grant_index, grant_onehot, exp);
            end
        end
    endtask

    task automatic test_stress();
        logic [N-1:0] prev_ack;
        logic         prev_v;
        logic         done_was;
        int           done_owner;
        int           svc_left;
        int           grants;
        int           cyc;
        do_reset();
        pend_q.delete();
        prev_ack   = '0;
        prev_v     = 1'b0;
        done_was   = 1'b0;
        done_owner = 0;
        svc_left   = 0;
        grants     = 0;
        cyc        = 0;
        while ((grants < 1000 || pend_q.size() != 0 || request != '0 || acknowledge != '0 || grant_valid)
               && cyc < 40000) begin
            @(posedge clock); #1;
            cyc++;
            n_checks++;
            if (grant_onehot !== (grant_valid ? (N'(1) << grant_index) : N'(0)) ||
                (!grant_valid && grant_index !== '0)) begin
                n_fail++;
                $display("FAIL stress_consistency cycle %0d: valid=%b index=%0d onehot=%b",
                         cyc, grant_valid, grant_index, grant_onehot);
            end
            if (done_was) begin
                n_checks++;
                if (grant_valid !== 1'b0 || acknowledge[done_owner] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stress_done cycle %0d: valid=%b ack=%b required 0 and ack[%0d]=1",
                             cyc, grant_valid, acknowledge, done_owner);
                end
            end else if (prev_v) begin
                n_checks++;
                if (grant_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stress_hold cycle %0d: valid=%b required 1", cyc, grant_valid);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (acknowledge[i] && !prev_ack[i]) begin
                    int pos;
                    pos = -1;
                    foreach (pend_q[j]) if (pend_q[j] == i && pos < 0) pos = j;
                    n_checks++;
                    if (!(done_was && done_owner == i) || pos < 0) begin
                        n_fail++;
                        $display("FAIL stress_ack_rise cycle %0d: ack[%0d] rose, done_owner=%0d done=%b pending=%0d",
                                 cyc, i, done_owner, done_was, pos);
                    end else begin
                        pend_q.delete(pos);
                    end
                end
                if (!acknowledge[i] && prev_ack[i]) begin
                    n_checks++;
                    if (request[i] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL stress_ack_fall cycle %0d: ack[%0d] fell with request=%b required 0",
                                 cyc, i, request[i]);
                    end
                end
            end
            if (grant_valid && !prev_v) begin
                grants++;
                n_checks++;
                if (request[grant_index] !== 1'b1 || prev_ack[grant_index] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stress_grant cycle %0d: index=%0d request=%b prev_ack=%b required 1 / 0",
                             cyc, grant_index, request[grant_index], prev_ack[grant_index]);
                end
                svc_left = $urandom_range(0, 3);
            end
            done_was = 1'b0;
            done     = 1'b0;
            if (grant_valid) begin
                if (svc_left == 0) begin
                    done       = 1'b1;
                    done_was   = 1'b1;
                    done_owner = int'(grant_index);
                end else begin
                    svc_left--;
                end
            end
            prev_ack = acknowledge;
            prev_v   = grant_valid;
            #($urandom_range(1, 7));
            for (int i = 0; i < N; i++) begin
                if (request[i] && acknowledge[i] && $urandom_range(0, 1) == 1) begin
                    request[i] = 1'b0;
                end else if (!request[i] && !acknowledge[i] && grants < 1000 &&
                             $urandom_range(0, 3) == 0) begin
                    request[i] = 1'b1;
                    pend_q.push_back(i);
                end
            end
        end
        done = 1'b0;
        n_checks++;
        if (pend_q.size() != 0 || grants < 1000) begin
            n_fail++;
            $display("FAIL stress_complete: grants=%0d unacknowledged=%0d required >=1000 / 0",
                     grants, pend_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_grant_gap();
        test_round_robin();
        test_spurious_done();
        test_reset_mid();
        test_stress();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/synchronized_request_arbiter.md
# synchronized_request_arbiter

Shares one single-clock resource between REQUESTERS asynchronous requesters, each driving a 4-phase request/acknowledge handshake from its own clock domain. Every request input passes through its own STAGES-deep flip-flop synchronizer. Synchronized requests are arbitrated round-robin into one registered grant. Acknowledges are returned straight from flops, so they are glitch-free for re-synchronization on the requester side.

## Interface
- REQUESTERS, 4, number of requesters (≥2)
- STAGES, 2, synchronizer flip-flop stages per request input (≥2)
- clock  input  1  resource clock; all flops on rising edge
- resetn  input  1  asynchronous active-low reset
- request  input  REQUESTERS  per-requester 4-phase request, asynchronous to clock
- acknowledge  output  REQUESTERS  per-requester 4-phase acknowledge, driven directly by a flop
- grant_valid  output  1  a requester currently owns the resource
- grant_index  output  max(1,$clog2(REQUESTERS))  index of the owner; 0 when grant_valid=0
- grant_onehot  output  REQUESTERS  one-hot owner; all zeros when grant_valid=0
- done  input  1  one-cycle pulse from the resource: current owner's service is complete

## Operation
- Synchronizer: request[i] → STAGES flops, reset to 0 → synced[i]. No other logic touches request[i].
- Eligibility: requester i is eligible when synced[i]=1, acknowledge[i]=0 and i is not currently granted.
- Arbiter FSM, two states:
  - IDLE: if any requester is eligible, register a grant to the first eligible index, searching from pointer+1 upward with wrap; pointer := granted index; go to BUSY. Otherwise stay in IDLE.
  - BUSY: grant outputs hold. On done=1: acknowledge[owner] := 1, grant outputs clear, go to IDLE.
- Acknowledge release: when acknowledge[i]=1 and synced[i]=0, acknowledge[i] := 0 on the next edge. This runs in parallel with the FSM.
- A requester may only re-raise request after it sees acknowledge low. Until then it is ineligible even if synced[i] stays high.
- done in IDLE is ignored. A request that drops while its owner is in BUSY does not abort the grant; the grant ends only on done. The requester protocol forbids this case.
- Pointer: reset value REQUESTERS-1, so priority after reset starts at index 0. Search wraps modulo REQUESTERS.
- Reset, asynchronous, also applies mid-operation:
  - acknowledge=0, grant_valid=0, grant_index=0, grant_onehot=0, FSM=IDLE, pointer=REQUESTERS-1, all synchronizer flops=0.
  - A requester whose request is still high after reset is treated as a new request and served again.

## Timing
- Request latency: request[i] rises before clock edge k. synced[i]=1 after edge k+STAGES-1. In IDLE, grant_valid=1 after edge k+STAGES, i.e. STAGES+1 edges.
- done sampled high at edge t: after edge t, grant_valid=0 and acknowledge[owner]=1. The earliest next grant is after edge t+1, so grant_valid is low for at least one full cycle between owners.
- Acknowledge fall: request[i] falls before edge k. acknowledge[i]=0 after edge k+STAGES.
- Minimum full 4-phase cycle for one requester, ignoring requester-side latency: STAGES+1 edges to grant, then service, 1 edge to acknowledge, then STAGES edges to release.
- Simultaneous events in the same cycle are independent:
  - acknowledge release for requester j
  - done for owner i
  - a new request synchronizing for requester k
- grant_valid, grant_index and grant_onehot are all registered and mutually consistent every cycle.

## Test plan
- Single requester, REQUESTERS=4, STAGES=2:
  - Stimulus: request[2] raised mid-cycle; done pulsed 5 cycles after the grant; request[2] dropped on acknowledge.
  - Response: grant_valid with grant_index=2 and grant_onehot=0100 exactly 3 edges after the first sampling edge; acknowledge[2]=1 one edge after done; acknowledge[2]=0 exactly 2 edges after the request fall is sampled.
- Round-robin fairness:
  - Stimulus: all four requests held high; each requester re-raises immediately after its acknowledge falls; done pulsed 2 cycles after every grant.
  - Response: grant order 0,1,2,3,0,1,… with no index served twice before every other waiting index is served once.
- Grant gap: done asserted while others are eligible → grant_valid low for exactly 1 cycle, then the next index is granted.
- Spurious done:
  - Stimulus: done pulsed in IDLE, and done pulsed while acknowledge[i] is already high.
  - Response: no output changes.
- Reset mid-operation:
  - Stimulus: resetn asserted while BUSY with owner 3 and acknowledge[1]=1.
  - Response: all outputs 0 immediately (asynchronously). After release with request[3] still high, index 3 is granted STAGES+1 edges later; index 0 wins if also pending.
- Random stress:
  - Stimulus: asynchronous request edges at random sub-cycle offsets with protocol-compliant requester models; 1000 grants.
  - Response:
    - never two owners at once;
    - acknowledge rises only after done for that owner;
    - no acknowledge pulse shorter than one clock period;
    - every request eventually acknowledged.
